ptmch_evt_cnt: RTL and testbench

PTMCH_EVT_CNT -- requirements
Module: ptmch_evt_cnt

---
 rtl/ptmch_evt_pkg.sv | 18 +
 rtl/ptmch_evt_filt.sv | 34 +++
 rtl/ptmch_evt_cnt.sv | 87 ++++++++
 tb/tb_ptmch_evt_cnt.sv | 242 ++++++++++++++++++++++++
 4 files changed

// File: rtl/ptmch_evt_pkg.sv
// ptmch_evt_pkg: default parameters, channel indices and helpers shared by the PTMCH event counter
package ptmch_evt_pkg;
  localparam int DEF_NUM_CH   = 5;
  localparam int DEF_CNT_W    = 32;
  localparam int DEF_FILT_LEN = 2;
  localparam int DEF_PADDR_W  = 6;
  localparam int STAB_W       = 4;
  typedef enum logic [3:0] {
    CH_PRGEXCT = 4'd0,
    CH_RDSTAT  = 4'd1,
    CH_BLKERS  = 4'd2,
    CH_PDREAD  = 4'd3,
    CH_WRSTAT  = 4'd4
  } ch_e;
  function automatic int sel_w(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction
endpackage

// File: rtl/ptmch_evt_filt.sv
// ptmch_evt_filt: per-channel 2-FF synchroniser, stability filter and rising-edge detector
module ptmch_evt_filt
  import ptmch_evt_pkg::*;
#(
  parameter int FILT_LEN = DEF_FILT_LEN
) (
  input  logic CLK100M,
  input  logic RESET_N,
  input  logic i_trg,
  output logic o_rise
);
  logic [1:0]        r_sync;
  logic              r_filt;
  logic              r_prev;
  logic [STAB_W-1:0] r_stab;
  // r_stab counts consecutive cycles the synchronised level disagrees with the filtered one
  always_ff @(posedge CLK100M or negedge RESET_N) begin
    if (!RESET_N) begin
      r_sync <= '0;
      r_filt <= 1'b0;
      r_prev <= 1'b0;
      r_stab <= '0;
    end else begin
      r_sync <= {r_sync[0], i_trg};
      r_prev <= r_filt;
      if (r_sync[1] == r_filt) r_stab <= '0;
      else if (r_stab == STAB_W'(FILT_LEN - 1)) begin
        r_filt <= r_sync[1];
        r_stab <= '0;
      end else r_stab <= r_stab + 1'b1;
    end
  end
  assign o_rise = r_filt & ~r_prev;
endmodule

// File: rtl/ptmch_evt_cnt.sv
// ptmch_evt_cnt: filtered per-channel rising-edge counters with snapshot, saturation and select readout
// Optional threshold interrupt enabled by defining PTMCH_EVT_IRQ_EN; otherwise IRQ is tied low.
module ptmch_evt_cnt
  import ptmch_evt_pkg::*;
#(
  parameter int  NUM_CH   = DEF_NUM_CH,
  parameter int  CNT_W    = DEF_CNT_W,
  parameter int  FILT_LEN = DEF_FILT_LEN,
  parameter int  PADDR_W  = DEF_PADDR_W,
  localparam int SEL_W    = sel_w(NUM_CH)
) (
  input  logic                    CLK100M,
  input  logic                    RESET_N,
  input  logic [NUM_CH-1:0]       TRG_PLS,
  input  logic                    CNT_EN,
  input  logic [NUM_CH-1:0]       CLR,
  input  logic                    SNAP,
  input  logic [SEL_W-1:0]        CH_SEL,
  input  logic [CNT_W-1:0]        IRQ_THR,
  input  logic                    IRQ_CLR,
  output logic [NUM_CH*CNT_W-1:0] CNT_SNAP,
  output logic [NUM_CH-1:0]       OVF,
  output logic [PADDR_W-1:0]      PADDR_CNT,
  output logic                    PLS_RISE,
  output logic                    IRQ
);
  localparam logic [CNT_W-1:0] CNT_MAX = '1;
  logic [NUM_CH-1:0] w_rise;
  logic [NUM_CH-1:0] w_evt;
  logic [CNT_W-1:0]  r_cnt [NUM_CH];
  logic [CNT_W-1:0]  w_nxt [NUM_CH];
  logic [SEL_W-1:0]  w_sel;
  genvar i;
  for (i = 0; i < NUM_CH; i++) begin : g_ch
    ptmch_evt_filt #(.FILT_LEN(FILT_LEN)) u_filt (
      .CLK100M(CLK100M),
      .RESET_N(RESET_N),
      .i_trg  (TRG_PLS[i]),
      .o_rise (w_rise[i])
    );
  end
  assign w_evt = w_rise & {NUM_CH{CNT_EN}};
  assign w_sel = (32'(CH_SEL) < NUM_CH) ? CH_SEL : '0;
  // Clear beats a coincident event; a saturated counter holds at all-ones
  always_comb begin
    for (int c = 0; c < NUM_CH; c++)
      w_nxt[c] = CLR[c] ? '0 : (w_evt[c] && r_cnt[c] != CNT_MAX) ? r_cnt[c] + 1'b1 : r_cnt[c];
  end
  always_ff @(posedge CLK100M or negedge RESET_N) begin
    if (!RESET_N) begin
      for (int c = 0; c < NUM_CH; c++) r_cnt[c] <= '0;
      CNT_SNAP  <= '0;
      OVF       <= '0;
      PADDR_CNT <= '0;
      PLS_RISE  <= 1'b0;
    end else begin
      for (int c = 0; c < NUM_CH; c++) begin
        r_cnt[c] <= w_nxt[c];
        OVF[c]   <= !CLR[c] && (OVF[c] || (w_evt[c] && r_cnt[c] == CNT_MAX));
        if (SNAP) CNT_SNAP[c*CNT_W +: CNT_W] <= r_cnt[c];
      end
      PADDR_CNT <= r_cnt[w_sel][PADDR_W-1:0];
      PLS_RISE  <= w_evt[w_sel];
    end
  end
`ifdef PTMCH_EVT_IRQ_EN
  logic [NUM_CH-1:0] r_chg;
  logic [NUM_CH-1:0] w_hit;
  always_comb begin
    for (int c = 0; c < NUM_CH; c++) w_hit[c] = r_chg[c] && r_cnt[c] == IRQ_THR;
  end
  // r_chg marks counters that changed at the last edge, so IRQ fires only on a transition into IRQ_THR
  always_ff @(posedge CLK100M or negedge RESET_N) begin
    if (!RESET_N) begin
      r_chg <= '0;
      IRQ   <= 1'b0;
    end else begin
      for (int c = 0; c < NUM_CH; c++) r_chg[c] <= w_nxt[c] != r_cnt[c];
      IRQ <= (|w_hit) || (IRQ && !IRQ_CLR);
    end
  end
`else
  logic w_unused;
  assign w_unused = ^{IRQ_THR, IRQ_CLR};
  assign IRQ = 1'b0;
`endif
endmodule

// File: tb/tb_ptmch_evt_cnt.sv
// tb_ptmch_evt_cnt: directed scoreboard bench for ptmch_evt_cnt (NUM_CH=5, CNT_W=8, FILT_LEN=2)
module tb_ptmch_evt_cnt;
  import ptmch_evt_pkg::*;
  localparam int NCH = 5;
  localparam int CW  = 8;
  localparam int PW  = 6;
`ifdef PTMCH_EVT_IRQ_EN
  localparam logic [31:0] IRQ_ON = 32'd1;
`else
  localparam logic [31:0] IRQ_ON = 32'd0;
`endif
  logic              CLK100M = 1'b0;
  logic              RESET_N = 1'b1;
  logic [NCH-1:0]    TRG_PLS = '0;
  logic              CNT_EN  = 1'b1;
  logic [NCH-1:0]    CLR     = '0;
  logic              SNAP    = 1'b0;
  logic [2:0]        CH_SEL  = '0;
  logic [CW-1:0]     IRQ_THR = '0;
  logic              IRQ_CLR = 1'b0;
  logic [NCH*CW-1:0] CNT_SNAP;
  logic [NCH-1:0]    OVF;
  logic [PW-1:0]     PADDR_CNT;
  logic              PLS_RISE;
  logic              IRQ;

  ptmch_evt_cnt #(.NUM_CH(NCH), .CNT_W(CW), .FILT_LEN(2), .PADDR_W(PW)) dut (
    .CLK100M(CLK100M), .RESET_N(RESET_N), .TRG_PLS(TRG_PLS), .CNT_EN(CNT_EN),
    .CLR(CLR), .SNAP(SNAP), .CH_SEL(CH_SEL), .IRQ_THR(IRQ_THR), .IRQ_CLR(IRQ_CLR),
    .CNT_SNAP(CNT_SNAP), .OVF(OVF), .PADDR_CNT(PADDR_CNT), .PLS_RISE(PLS_RISE), .IRQ(IRQ)
  );

  always #5 CLK100M = ~CLK100M;

  typedef enum {K_SNAP, K_OVF, K_PADDR, K_RISE, K_IRQ, K_RCNT} kind_e;
  typedef struct {
    string       name;
    kind_e       kind;
    int          ch;
    logic [31:0] exp;
  } item_t;
  item_t       q[$];
  item_t       m_it;
  logic [31:0] m_act;
  int          n_tests  = 0;
  int          n_fail   = 0;
  int          rise_cnt = 0;

  always @(negedge CLK100M) begin
    if (PLS_RISE === 1'b1) rise_cnt++;
    while (q.size() > 0) begin
      m_it = q.pop_front();
      case (m_it.kind)
        K_SNAP:  m_act = 32'(CNT_SNAP[m_it.ch*CW +: CW]);
        K_OVF:   m_act = 32'(OVF[m_it.ch]);
        K_PADDR: m_act = 32'(PADDR_CNT);
        K_RISE:  m_act = 32'(PLS_RISE);
        K_IRQ:   m_act = 32'(IRQ);
        default: begin
          m_act    = 32'(rise_cnt);
          rise_cnt = 0;
        end
      endcase
      n_tests++;
      if (m_act !== m_it.exp) begin
        n_fail++;
        $display("FAIL %s: got %0d expected %0d", m_it.name, m_act, m_it.exp);
      end
    end
  end

  initial begin
    repeat (200000) @(posedge CLK100M);
    n_fail++;
    $display("FAIL timeout: sequence did not finish within 200000 cycles");
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

  task automatic tick(input int n);
    repeat (n) @(posedge CLK100M);
    #1;
  endtask

  task automatic chk(input string nm, input kind_e k, input int ch, input logic [31:0] e);
    q.push_back('{name: nm, kind: k, ch: ch, exp: e});
  endtask

  task automatic pulse(input int ch, input int n);
    repeat (n) begin
      TRG_PLS[ch] = 1'b1;
      tick(4);
      TRG_PLS[ch] = 1'b0;
      tick(4);
    end
  endtask

  task automatic snap_chk(input string nm, input int ch, input logic [31:0] e);
    SNAP = 1'b1;
    tick(1);
    SNAP = 1'b0;
    chk(nm, K_SNAP, ch, e);
  endtask

  initial begin
    #1 RESET_N = 1'b0;
    #1;
    n_tests++;
    if (CNT_SNAP !== '0 || OVF !== '0 || PADDR_CNT !== '0 || PLS_RISE !== 1'b0 || IRQ !== 1'b0) begin
      n_fail++;
      $display("FAIL rst_all: outputs not zero during reset");
    end
    chk("rst_snap0", K_SNAP, 0, 0);
    chk("rst_ovf2", K_OVF, 2, 0);
    chk("rst_paddr", K_PADDR, 0, 0);
    chk("rst_rise", K_RISE, 0, 0);
    chk("rst_irq", K_IRQ, 0, 0);
    tick(2);
    RESET_N = 1'b1;
    tick(3);
    TRG_PLS[CH_PRGEXCT] = 1'b1;
    tick(1);
    TRG_PLS[CH_PRGEXCT] = 1'b0;
    tick(8);
    chk("glitch_paddr", K_PADDR, 0, 0);
    chk("glitch_rise", K_RCNT, 0, 0);
    snap_chk("glitch_cnt", 0, 0);
    TRG_PLS[CH_PRGEXCT] = 1'b1;
    tick(4);
    chk("lat_rise_early", K_RISE, 0, 0);
    chk("lat_paddr_k3", K_PADDR, 0, 0);
    SNAP = 1'b1;
    tick(1);
    chk("lat_rise", K_RISE, 0, 1);
    chk("lat_paddr_k4", K_PADDR, 0, 0);
    chk("lat_snap_k4", K_SNAP, 0, 0);
    tick(1);
    SNAP = 1'b0;
    chk("lat_snap_k5", K_SNAP, 0, 1);
    chk("lat_rise_end", K_RISE, 0, 0);
    chk("lat_paddr_k5", K_PADDR, 0, 1);
    tick(5);
    TRG_PLS[CH_PRGEXCT] = 1'b0;
    tick(8);
    chk("lat_rise_once", K_RCNT, 0, 1);
    snap_chk("lat_cnt", 0, 1);
    CNT_EN = 1'b0;
    pulse(0, 3);
    CNT_EN = 1'b1;
    tick(1);
    chk("en_paddr", K_PADDR, 0, 1);
    chk("en_rise", K_RCNT, 0, 0);
    snap_chk("en_cnt", 0, 1);
    CH_SEL = 3'd7;
    tick(2);
    chk("sel_oob", K_PADDR, 0, 1);
    pulse(CH_PDREAD, 1);
    chk("sel_oob_ch3", K_PADDR, 0, 1);
    pulse(0, 1);
    chk("sel_oob_follow", K_PADDR, 0, 2);
    chk("sel_oob_rise", K_RCNT, 0, 1);
    CH_SEL = 3'd3;
    tick(2);
    chk("sel_ch3", K_PADDR, 0, 1);
    CH_SEL = 3'd0;
    tick(1);
    pulse(CH_RDSTAT, 2);
    snap_chk("clr_pre", 1, 2);
    TRG_PLS[CH_RDSTAT] = 1'b1;
    tick(4);
    CLR = 5'b00010;
    tick(1);
    CLR = '0;
    tick(6);
    TRG_PLS[CH_RDSTAT] = 1'b0;
    tick(8);
    snap_chk("clr_vs_rise", 1, 0);
    chk("clr_ovf1", K_OVF, 1, 0);
    pulse(CH_PDREAD, 4);
    TRG_PLS[CH_PDREAD] = 1'b1;
    tick(4);
    SNAP = 1'b1;
    tick(1);
    SNAP = 1'b0;
    chk("snap_vs_rise", K_SNAP, 3, 5);
    tick(6);
    TRG_PLS[CH_PDREAD] = 1'b0;
    tick(8);
    snap_chk("snap_live", 3, 6);
    pulse(CH_BLKERS, 255);
    snap_chk("sat_255", 2, 255);
    chk("sat_ovf_pre", K_OVF, 2, 0);
    pulse(CH_BLKERS, 1);
    snap_chk("sat_hold", 2, 255);
    chk("sat_ovf", K_OVF, 2, 1);
    chk("sat_ovf0", K_OVF, 0, 0);
    CLR = 5'b00100;
    tick(1);
    CLR = '0;
    snap_chk("sat_clr_cnt", 2, 0);
    chk("sat_clr_ovf", K_OVF, 2, 0);
    IRQ_THR = 8'd3;
    IRQ_CLR = 1'b1;
    tick(1);
    IRQ_CLR = 1'b0;
    tick(1);
    chk("irq_idle", K_IRQ, 0, 0);
    pulse(CH_WRSTAT, 2);
    chk("irq_two", K_IRQ, 0, 0);
    pulse(CH_WRSTAT, 1);
    chk("irq_three", K_IRQ, 0, IRQ_ON);
    tick(3);
    chk("irq_sticky", K_IRQ, 0, IRQ_ON);
    IRQ_CLR = 1'b1;
    tick(1);
    IRQ_CLR = 1'b0;
    chk("irq_clr", K_IRQ, 0, 0);
    pulse(CH_WRSTAT, 1);
    chk("irq_past_thr", K_IRQ, 0, 0);
    TRG_PLS[CH_PRGEXCT] = 1'b1;
    tick(3);
    RESET_N = 1'b0;
    #1;
    chk("mrst_snap0", K_SNAP, 0, 0);
    chk("mrst_snap3", K_SNAP, 3, 0);
    chk("mrst_paddr", K_PADDR, 0, 0);
    chk("mrst_rise", K_RISE, 0, 0);
    tick(2);
    RESET_N = 1'b1;
    tick(10);
    chk("mrst_rise_once", K_RCNT, 0, 1);
    chk("mrst_paddr_1", K_PADDR, 0, 1);
    snap_chk("mrst_cnt", 0, 1);
    TRG_PLS[CH_PRGEXCT] = 1'b0;
    tick(8);
    snap_chk("mrst_cnt_hold", 0, 1);
    chk("mrst_rise_none", K_RCNT, 0, 0);
    tick(2);
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end
endmodule
